// File: rtl/yc_timing_pkg.sv
// Shared timing defaults, FSM encoding and window helper for the composite line sequencer.
package yc_timing_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LINE   = 2'd2;

  localparam int unsigned DEF_DATA_WIDTH   = 12;
  localparam int unsigned DEF_SEP_LATENCY  = 17;
  localparam int          DEF_SYNC_THRESH  = 256;
  localparam int unsigned DEF_SYNC_MIN     = 256;
  localparam int unsigned DEF_LINE_MIN     = 4400;
  localparam int unsigned DEF_LINE_TIMEOUT = 5200;
  localparam int unsigned DEF_BURST_START  = 45;
  localparam int unsigned DEF_BURST_LEN    = 186;
  localparam int unsigned DEF_ACTIVE_START = 350;
  localparam int unsigned DEF_ACTIVE_LEN   = 3900;
  localparam int unsigned DEF_LOCK_LINES   = 3;
  localparam int          DEF_BLANK_LEVEL  = 600;

  localparam int unsigned POS_W  = $clog2(DEF_LINE_TIMEOUT + 1);
  localparam int unsigned LINE_W = 10;

  function automatic logic in_window(input int unsigned p, input int unsigned start,
                                     input int unsigned len);
    return (p >= start) && (p < start + len);
  endfunction

endpackage

// File: rtl/pulse_delay_line.sv
// Fixed-depth shift register; every stage clears on reset so no stale gate survives it.
module pulse_delay_line #(
  parameter int unsigned DEPTH = 17,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/composite_line_sequencer.sv
// Horizontal sync detection, line lock and gate generation in front of the Y/C separator.
module composite_line_sequencer
  import yc_timing_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned SEP_LATENCY  = DEF_SEP_LATENCY,
  parameter int          SYNC_THRESH  = DEF_SYNC_THRESH,
  parameter int unsigned SYNC_MIN     = DEF_SYNC_MIN,
  parameter int unsigned LINE_MIN     = DEF_LINE_MIN,
  parameter int unsigned LINE_TIMEOUT = DEF_LINE_TIMEOUT,
  parameter int unsigned BURST_START  = DEF_BURST_START,
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned ACTIVE_START = DEF_ACTIVE_START,
  parameter int unsigned ACTIVE_LEN   = DEF_ACTIVE_LEN,
  parameter int unsigned LOCK_LINES   = DEF_LOCK_LINES,
  parameter int          BLANK_LEVEL  = DEF_BLANK_LEVEL
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] sep_data,
  output logic                         sep_rst,
  output logic                         burst_gate,
  output logic                         active_valid,
  output logic                         hsync_pulse,
  output logic                         locked,
  output logic [LINE_W-1:0]            line_num
);

  // Never narrower than the package default position width.
  localparam int unsigned PW = ($clog2(LINE_TIMEOUT + 1) > POS_W) ? $clog2(LINE_TIMEOUT + 1)
                                                                  : POS_W;
  localparam int unsigned LW = $clog2(SYNC_MIN + 1);
  localparam int unsigned GW = $clog2(LOCK_LINES + 1);

  localparam logic signed [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(SYNC_THRESH);
  localparam logic signed [DATA_WIDTH-1:0] BLANK  = DATA_WIDTH'(BLANK_LEVEL);
  localparam logic [LW-1:0] LOW_MAX  = LW'(SYNC_MIN);
  localparam logic [LW-1:0] LOW_HIT  = LW'(SYNC_MIN - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(LINE_TIMEOUT);
  localparam logic [PW-1:0] POS_LAST = PW'(LINE_TIMEOUT - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(LINE_MIN);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LINES);

  logic [1:0]              state_q, state_d;
  logic [LW-1:0]           low_cnt_q, low_cnt_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [GW-1:0]           good_q, good_d;
  logic                    locked_q, locked_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    hsync_q, hsync_d;
  logic signed [DATA_WIDTH-1:0] sep_data_q, sep_data_d;
  logic                    sep_rst_q;
  logic                    burst_q, burst_d;
  logic                    active_pre_q, active_pre_d;
  logic                    low, sync_hit;

  assign low      = data_in < THRESH;
  assign sync_hit = low && (low_cnt_q == LOW_HIT);

  always_comb begin
    if (!low)                   low_cnt_d = '0;
    else if (low_cnt_q == LOW_MAX) low_cnt_d = low_cnt_q;
    else                        low_cnt_d = low_cnt_q + LW'(1);
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = (pos_q == POS_MAX) ? pos_q : pos_q + PW'(1);
    good_d   = good_q;
    locked_d = locked_q;
    line_d   = line_q;
    hsync_d  = 1'b0;
    case (state_q)
      ST_SEARCH: if (sync_hit) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!low) begin
          state_d = ST_LINE;
          pos_d   = '0;
          hsync_d = 1'b1;
        end
      end
      ST_LINE: begin
        // Timeout has priority over a sync landing on the same sample.
        if (pos_q >= POS_LAST) begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          good_d   = '0;
        end else if (sync_hit) begin
          state_d = ST_SYNC;
          if (pos_q >= POS_FULL) begin
            if (good_q != GOOD_MAX) good_d = good_q + GW'(1);
            if (good_d == GOOD_MAX) locked_d = 1'b1;
            line_d = line_q + LINE_W'(1);
          end else begin
            line_d = '0;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    sep_data_d   = (state_q == ST_SYNC) ? BLANK : data_in;
    burst_d      = locked_q && (state_q == ST_LINE) &&
                   in_window(32'(pos_q), BURST_START, BURST_LEN);
    active_pre_d = locked_q && (state_q == ST_LINE) &&
                   in_window(32'(pos_q), ACTIVE_START, ACTIVE_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEARCH;
      low_cnt_q    <= '0;
      pos_q        <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      line_q       <= '0;
      hsync_q      <= 1'b0;
      sep_data_q   <= '0;
      sep_rst_q    <= 1'b1;
      burst_q      <= 1'b0;
      active_pre_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      low_cnt_q    <= low_cnt_d;
      pos_q        <= pos_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      line_q       <= line_d;
      hsync_q      <= hsync_d;
      sep_data_q   <= sep_data_d;
      sep_rst_q    <= !locked_q;
      burst_q      <= burst_d;
      active_pre_q <= active_pre_d;
    end
  end

  pulse_delay_line #(
    .DEPTH (SEP_LATENCY),
    .WIDTH (1)
  ) u_active_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (active_pre_q),
    .dout  (active_valid)
  );

  assign sep_data    = sep_data_q;
  assign sep_rst     = sep_rst_q;
  assign burst_gate  = burst_q;
  assign hsync_pulse = hsync_q;
  assign locked      = locked_q;
  assign line_num    = line_q;

endmodule

// File: tb/tb_composite_line_sequencer.sv
// Directed segment table for composite_line_sequencer plus timeout and mid-line reset cases.
module tb_composite_line_sequencer;

  localparam int DW = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] sep_data;
  logic                 sep_rst, burst_gate, active_valid, hsync_pulse, locked;
  logic [9:0]           line_num;

  always #5 clk = ~clk;

  composite_line_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .sep_data     (sep_data),
    .sep_rst      (sep_rst),
    .burst_gate   (burst_gate),
    .active_valid (active_valid),
    .hsync_pulse  (hsync_pulse),
    .locked       (locked),
    .line_num     (line_num)
  );

  // hi: 1500 line (optional embedded low pulse), else 0-level sync tip.
  // lk: gates expected during this line; act_head: leading samples with a draining active gate.
  typedef struct {
    bit hi;
    int len;
    int pulse_at;
    int pulse_len;
    bit lk;
    int act_head;
    int exp_line;
    bit exp_locked;
    bit exp_sep_rst;
  } seg_t;

  seg_t  tbl [22];
  int    n_checks = 0;
  int    n_fail = 0;
  int    bad [4];
  int    bidx [4];
  int    bgot [4];
  int    bexp [4];
  string oname [4] = '{"sep_data", "hsync_pulse", "burst_gate", "active_valid"};

  task automatic step(input logic signed [DW-1:0] v);
    data_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic note(input int k, input int i, input int got, input int exp);
    if (got != exp) begin
      if (bad[k] == 0) begin
        bidx[k] = i;
        bgot[k] = got;
        bexp[k] = exp;
      end
      bad[k]++;
    end
  endtask

  task automatic seg_report(input int id);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bad[k] != 0) begin
        n_fail++;
        $display("FAIL seg%0d %s: %0d bad samples, first at idx %0d got %0d expected %0d",
                 id, oname[k], bad[k], bidx[k], bgot[k], bexp[k]);
      end
    end
  endtask

  task automatic run_seg(input seg_t s, input int id);
    bit in_pulse;
    int e_sep;
    int e_hs, e_b, e_a;
    for (int k = 0; k < 4; k++) bad[k] = 0;
    for (int i = 0; i < s.len; i++) begin
      if (s.hi) begin
        in_pulse = (s.pulse_len > 0) && (i >= s.pulse_at) && (i < s.pulse_at + s.pulse_len);
        step(in_pulse ? 12'sd0 : 12'sd1500);
        e_sep = (i == 0) ? 600 : (in_pulse ? 0 : 1500);
        e_hs  = (i == 0) ? 1 : 0;
        e_b   = (s.lk && i >= 46 && i <= 231) ? 1 : 0;
        e_a   = ((i < s.act_head) || (s.lk && i >= 368 && i <= 4267)) ? 1 : 0;
      end else begin
        step(12'sd0);
        e_sep = (i >= 256) ? 600 : 0;
        e_hs  = 0;
        e_b   = 0;
        e_a   = (i < s.act_head) ? 1 : 0;
      end
      note(0, i, int'(sep_data), e_sep);
      note(1, i, int'(hsync_pulse), e_hs);
      note(2, i, int'(burst_gate), e_b);
      note(3, i, int'(active_valid), e_a);
    end
    seg_report(id);
    check($sformatf("seg%0d line_num", id), int'(line_num), s.exp_line);
    check($sformatf("seg%0d locked", id), int'(locked), int'(s.exp_locked));
    check($sformatf("seg%0d sep_rst", id), int'(sep_rst), int'(s.exp_sep_rst));
  endtask

  initial begin
    int hs_seen;
    //          hi  len  pa    pl   lk ah   line L  R
    tbl[0]  = '{0, 300,  0,    0,   0, 0,   0,   0, 1};
    tbl[1]  = '{1, 4415, 0,    0,   0, 0,   0,   0, 1};
    tbl[2]  = '{0, 300,  0,    0,   0, 0,   1,   0, 1};
    tbl[3]  = '{1, 4415, 0,    0,   0, 0,   1,   0, 1};
    tbl[4]  = '{0, 300,  0,    0,   0, 0,   2,   0, 1};
    tbl[5]  = '{1, 4415, 0,    0,   0, 0,   2,   0, 1};
    tbl[6]  = '{0, 300,  0,    0,   0, 0,   3,   1, 0};
    tbl[7]  = '{1, 4415, 0,    0,   1, 0,   3,   1, 0};
    tbl[8]  = '{0, 300,  0,    0,   0, 0,   4,   1, 0};
    tbl[9]  = '{1, 4415, 1000, 170, 1, 0,   4,   1, 0};
    tbl[10] = '{0, 300,  0,    0,   0, 0,   5,   1, 0};
    tbl[11] = '{1, 2000, 0,    0,   1, 0,   5,   1, 0};
    tbl[12] = '{0, 256,  0,    0,   0, 256, 0,   1, 0};
    tbl[13] = '{1, 4415, 0,    0,   1, 17,  0,   1, 0};
    tbl[14] = '{0, 300,  0,    0,   0, 0,   1,   1, 0};
    tbl[15] = '{0, 300,  0,    0,   0, 0,   1,   0, 1};
    tbl[16] = '{1, 4415, 0,    0,   0, 0,   1,   0, 1};
    tbl[17] = '{0, 300,  0,    0,   0, 0,   2,   0, 1};
    tbl[18] = '{1, 4415, 0,    0,   0, 0,   2,   0, 1};
    tbl[19] = '{0, 300,  0,    0,   0, 0,   3,   0, 1};
    tbl[20] = '{1, 4415, 0,    0,   0, 0,   3,   0, 1};
    tbl[21] = '{0, 300,  0,    0,   0, 0,   4,   1, 0};

    // Reset with an idle level present.
    rst_n   = 1'b0;
    data_in = 12'sd2000;
    hs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(12'sd2000);
      hs_seen += int'(hsync_pulse);
    end
    check("reset sep_data", int'(sep_data), 0);
    check("reset sep_rst", int'(sep_rst), 1);
    check("reset burst_gate", int'(burst_gate), 0);
    check("reset active_valid", int'(active_valid), 0);
    check("reset locked", int'(locked), 0);
    check("reset line_num", int'(line_num), 0);
    check("reset hsync count", hs_seen, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(12'sd2000);
      hs_seen += int'(hsync_pulse);
    end
    check("idle hsync count", hs_seen, 0);
    check("idle sep_data", int'(sep_data), 2000);
    check("idle sep_rst", int'(sep_rst), 1);

    for (int s = 0; s <= 14; s++) run_seg(tbl[s], s);

    // Locked line with no further sync: lock drops when pos reaches the timeout.
    hs_seen = 0;
    for (int i = 0; i < 5202; i++) begin
      step(12'sd1500);
      if (i == 0) check("timeout hsync at sync end", int'(hsync_pulse), 1);
      else hs_seen += int'(hsync_pulse);
      if (i == 5199) check("timeout locked before", int'(locked), 1);
      if (i == 5200) begin
        check("timeout locked at 5200", int'(locked), 0);
        check("timeout sep_rst same cycle", int'(sep_rst), 0);
      end
      if (i == 5201) check("timeout sep_rst next cycle", int'(sep_rst), 1);
    end
    check("timeout stray hsync", hs_seen, 0);

    for (int s = 15; s <= 21; s++) run_seg(tbl[s], s);

    // Reset asserted in the middle of active video.
    for (int i = 0; i < 1000; i++) step(12'sd1500);
    check("pre-reset active_valid", int'(active_valid), 1);
    check("pre-reset line_num", int'(line_num), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset sep_data", int'(sep_data), 0);
    check("async reset sep_rst", int'(sep_rst), 1);
    check("async reset active_valid", int'(active_valid), 0);
    check("async reset locked", int'(locked), 0);
    check("async reset line_num", int'(line_num), 0);
    check("async reset burst_gate", int'(burst_gate), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset active_valid", int'(active_valid), 0);
    check("post-reset locked", int'(locked), 0);
    check("post-reset sep_rst", int'(sep_rst), 1);
    check("post-reset sep_data", int'(sep_data), 1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
